// File: rtl/gpi_debounce_pkg.sv
// Shared defaults and sizing helper for the general-purpose input debouncer.
package gpi_debounce_pkg;

  localparam int unsigned DebounceCyclesDefault = 500000;
  localparam int unsigned SyncStagesDefault     = 2;

  // Counter must hold values up to DebounceCycles.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// One input bit: synchroniser, stability counter, accepted level and edge pulses.
module gpi_debounce_bit
  import gpi_debounce_pkg::*;
#(
  parameter int unsigned DebounceCycles = DebounceCyclesDefault,
  parameter int unsigned SyncStages     = SyncStagesDefault
) (
  input  logic clk_sys_i,
  input  logic rst_sys_i,
  input  logic raw_i,
  output logic debounced_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  (* ASYNC_REG = "TRUE" *) logic [SyncStages-1:0] sync_q;
  logic [SyncStages-1:0] sync_d;
  logic                  sync;

  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  assign sync_d = {sync_q[SyncStages-2:0], raw_i};
  assign sync   = sync_q[SyncStages-1];

  // Accept a new level only after it has differed for DebounceCycles edges in a row.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d = sync;
      cnt_d    = '0;
      rise_d   = sync;
      fall_d   = ~sync;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign debounced_o = stable_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;

endmodule

// File: rtl/gpi_debounce.sv
// Per-bit debounce of asynchronous board inputs with rise/fall pulses.
module gpi_debounce
  import gpi_debounce_pkg::*;
#(
  parameter int unsigned Width          = 8,
  parameter int unsigned DebounceCycles = DebounceCyclesDefault,
  parameter int unsigned SyncStages     = SyncStagesDefault
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] raw_i,
  output logic [Width-1:0] debounced_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  for (genvar i = 0; i < Width; i++) begin : g_bit
    gpi_debounce_bit #(
      .DebounceCycles(DebounceCycles),
      .SyncStages    (SyncStages)
    ) u_bit (
      .clk_sys_i  (clk_sys_i),
      .rst_sys_i  (rst_sys_i),
      .raw_i      (raw_i[i]),
      .debounced_o(debounced_o[i]),
      .rise_o     (rise_o[i]),
      .fall_o     (fall_o[i])
    );
  end

endmodule
